// File: rtl/mem_refill_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the refill arbiter.
// The arbiter connects through the slave modport; caches and memory use the master modport.
interface mem_refill_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // A transfer occurs in a cycle where valid and ready are both 1; the sender holds
    // valid and payload stable until then. mem_rsp_valid has no ready and is never stalled.
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_req_ready;
    logic                  i_rsp_valid;
    logic [DATA_WIDTH-1:0] i_rsp_data;
    logic                  i_rsp_last;

    logic                  d_req_valid;
    logic                  d_req_write;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic                  d_req_ready;
    logic                  d_wdata_valid;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_wdata_ready;
    logic                  d_rsp_valid;
    logic [DATA_WIDTH-1:0] d_rsp_data;
    logic                  d_rsp_last;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_wdata_valid;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wdata_ready;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    logic [2:0]            dbg_state;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_last,
        input  d_req_valid, d_req_write, d_req_addr, d_wdata_valid, d_wdata,
        output d_req_ready, d_wdata_ready, d_rsp_valid, d_rsp_data, d_rsp_last,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata_valid, mem_wdata,
        input  mem_req_ready, mem_wdata_ready, mem_rsp_valid, mem_rsp_data,
        output dbg_state
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_last,
        output d_req_valid, d_req_write, d_req_addr, d_wdata_valid, d_wdata,
        input  d_req_ready, d_wdata_ready, d_rsp_valid, d_rsp_data, d_rsp_last,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata_valid, mem_wdata,
        output mem_req_ready, mem_wdata_ready, mem_rsp_valid, mem_rsp_data,
        input  dbg_state
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/writebacks,
// one line transaction at a time, D first with a bounded starvation guard for I.
module mem_refill_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LINE_WORDS   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_refill_arbiter_if.slave  bus
);
    localparam int OFFS  = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        WACK  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_d_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      beat_q;
    logic [SC_W-1:0]       starve_q;

    logic                  grant_i, grant_d, beat_fire, last_beat, starved;
    logic [ADDR_WIDTH-1:0] line_addr;

    assign starved   = (starve_q == SC_W'(STARVE_LIMIT));
    assign last_beat = (beat_q == CNT_W'(LINE_WORDS - 1));

    // rst_n gates the grants so the readies drop at once while reset is asserted.
    assign grant_i = rst_n && (state_q == IDLE) && bus.i_req_valid &&
                     (!bus.d_req_valid || starved);
    assign grant_d = rst_n && (state_q == IDLE) && bus.d_req_valid && !grant_i;

    assign beat_fire = ((state_q == READ)  && bus.mem_rsp_valid) ||
                       ((state_q == WRITE) && bus.d_wdata_valid && bus.mem_wdata_ready);

    assign line_addr = (grant_d ? bus.d_req_addr : bus.i_req_addr) & ~LOW_MASK;

    assign bus.dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.i_req_ready     = grant_i;
        bus.d_req_ready     = grant_d;
        bus.i_rsp_valid     = 1'b0;
        bus.i_rsp_data      = '0;
        bus.i_rsp_last      = 1'b0;
        bus.d_rsp_valid     = 1'b0;
        bus.d_rsp_data      = '0;
        bus.d_rsp_last      = 1'b0;
        bus.d_wdata_ready   = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_write   = 1'b0;
        bus.mem_req_addr    = '0;
        bus.mem_wdata_valid = 1'b0;
        bus.mem_wdata       = '0;

        case (state_q)
            IDLE: begin
                if (grant_i || grant_d) state_d = CMD;
            end
            CMD: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = write_q;
                bus.mem_req_addr  = addr_q;
                if (bus.mem_req_ready) state_d = write_q ? WRITE : READ;
            end
            READ: begin
                // Zero-latency pass-through; only the owner ever sees a beat.
                if (bus.mem_rsp_valid) begin
                    if (owner_d_q) begin
                        bus.d_rsp_valid = 1'b1;
                        bus.d_rsp_data  = bus.mem_rsp_data;
                        bus.d_rsp_last  = last_beat;
                    end else begin
                        bus.i_rsp_valid = 1'b1;
                        bus.i_rsp_data  = bus.mem_rsp_data;
                        bus.i_rsp_last  = last_beat;
                    end
                    if (last_beat) state_d = IDLE;
                end
            end
            WRITE: begin
                bus.mem_wdata_valid = bus.d_wdata_valid;
                bus.mem_wdata       = bus.d_wdata;
                bus.d_wdata_ready   = bus.mem_wdata_ready;
                if (beat_fire && last_beat) state_d = WACK;
            end
            WACK: begin
                bus.d_rsp_valid = 1'b1;
                bus.d_rsp_last  = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            beat_q    <= '0;
            starve_q  <= '0;
        end else begin
            if (grant_i || grant_d) begin
                owner_d_q <= grant_d;
                write_q   <= grant_d && bus.d_req_write;
                addr_q    <= line_addr;
            end

            if (beat_fire) begin
                beat_q <= last_beat ? '0 : beat_q + CNT_W'(1);
            end

            // Counts D wins that overtook a waiting I request; any idle I cycle forgives.
            if (!bus.i_req_valid || grant_i) begin
                starve_q <= '0;
            end else if (grant_d && !starved) begin
                starve_q <= starve_q + SC_W'(1);
            end
        end
    end
endmodule
